// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the iCache, dCache and memory-side handshake signals of
//            the two-requester line memory arbiter.
// Modports : slave  - the arbiter (takes requests, drives memory strobes)
//            master - the environment (caches + memory model)
// Signals  : i_req/i_addr/i_ready/i_line           iCache line reads
//            d_read/d_write/d_addr/d_wline/
//            d_ready/d_line                         dCache reads/writebacks
//            m_read/m_write/m_addr/m_wline/
//            m_line/m_ready                         memory port
//            grant                                  00 none, 01 I, 10 D
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [LINE_W-1:0] i_line;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wline;
    logic              d_ready;
    logic [LINE_W-1:0] d_line;

    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wline;
    logic [LINE_W-1:0] m_line;
    logic              m_ready;

    logic [1:0]        grant;

    modport slave (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wline, m_line, m_ready,
        output i_ready, i_line, d_ready, d_line, m_read, m_write, m_addr, m_wline, grant
    );

    modport master (
        output i_req, i_addr, d_read, d_write, d_addr, d_wline, m_line, m_ready,
        input  i_ready, i_line, d_ready, d_line, m_read, m_write, m_addr, m_wline, grant
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates iCache line reads and dCache line reads/writebacks
//            onto a single line-wide memory port. One transaction at a time:
//            IDLE -> SERVE_I/SERVE_D -> RELEASE -> IDLE.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - mem_arbiter_if.slave (cache requests, memory port, grant)
// Params   : ADDR_W - line address width, LINE_W - cache line width
// Config   : MEM_ARB_RR_EN - when defined, ties are resolved round-robin via
//            a last-served flag; otherwise the dCache always wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state;
    logic              m_read_reg;
    logic              m_write_reg;
    logic [ADDR_W-1:0] m_addr_reg;
    logic [LINE_W-1:0] m_wline_reg;
    logic              i_ready_reg;
    logic              d_ready_reg;
    logic [LINE_W-1:0] i_line_reg;
    logic [LINE_W-1:0] d_line_reg;
    logic [1:0]        grant_reg;

    logic d_req;
    logic pick_d;

    assign d_req = bus.d_read | bus.d_write;

`ifdef MEM_ARB_RR_EN
    // 0: iCache served last (so dCache wins the next tie), 1: dCache served last.
    logic last_d;
    assign pick_d = d_req & (~bus.i_req | ~last_d);
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            m_read_reg  <= 1'b0;
            m_write_reg <= 1'b0;
            m_addr_reg  <= '0;
            m_wline_reg <= '0;
            i_ready_reg <= 1'b0;
            d_ready_reg <= 1'b0;
            i_line_reg  <= '0;
            d_line_reg  <= '0;
            grant_reg   <= 2'b00;
`ifdef MEM_ARB_RR_EN
            last_d      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Request, address, data and operation are captured here so
                    // the memory side stays stable whatever the caches do later.
                    if (pick_d) begin
                        state       <= SERVE_D;
                        grant_reg   <= 2'b10;
                        m_addr_reg  <= bus.d_addr;
                        m_wline_reg <= bus.d_wline;
                        // Simultaneous read+write resolves to a writeback.
                        m_write_reg <= bus.d_write;
                        m_read_reg  <= ~bus.d_write;
                    end else if (bus.i_req) begin
                        state       <= SERVE_I;
                        grant_reg   <= 2'b01;
                        m_addr_reg  <= bus.i_addr;
                        m_read_reg  <= 1'b1;
                        m_write_reg <= 1'b0;
                    end
                end
                SERVE_I: begin
                    if (bus.m_ready) begin
                        state       <= RELEASE;
                        m_read_reg  <= 1'b0;
                        m_write_reg <= 1'b0;
                        grant_reg   <= 2'b00;
                        i_line_reg  <= bus.m_line;
                        i_ready_reg <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_d      <= 1'b0;
`endif
                    end
                end
                SERVE_D: begin
                    if (bus.m_ready) begin
                        state       <= RELEASE;
                        m_read_reg  <= 1'b0;
                        m_write_reg <= 1'b0;
                        grant_reg   <= 2'b00;
                        // A writeback returns no data; d_line keeps its value.
                        if (m_read_reg) begin
                            d_line_reg <= bus.m_line;
                        end
                        d_ready_reg <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_d      <= 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    // Requests are ignored for this cycle while the served
                    // requester withdraws its request.
                    state       <= IDLE;
                    i_ready_reg <= 1'b0;
                    d_ready_reg <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.m_read  = m_read_reg;
    assign bus.m_write = m_write_reg;
    assign bus.m_addr  = m_addr_reg;
    assign bus.m_wline = m_wline_reg;
    assign bus.i_ready = i_ready_reg;
    assign bus.d_ready = d_ready_reg;
    assign bus.i_line  = i_line_reg;
    assign bus.d_line  = d_line_reg;
    assign bus.grant   = grant_reg;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. Directed scenarios plus a
//            randomized transaction loop scored against a transaction-level
//            model (pending requests, winner selection, expected lines).
// Config   : MEM_ARB_RR_EN selects round-robin expectations for ties.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = '0;
        bus.d_wline = '0;
        bus.m_line  = '0;
        bus.m_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.m_read, bus.m_write, bus.i_ready, bus.d_ready, bus.grant} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.m_read, bus.m_write, bus.i_ready, bus.d_ready, bus.grant});
        end
        checks++;
        if ({bus.i_line, bus.d_line, bus.m_addr, bus.m_wline} !== '0) begin
            errors++;
            $display("FAIL reset_data: i_line=%h d_line=%h m_addr=%h m_wline=%h expected all 0",
                     bus.i_line, bus.d_line, bus.m_addr, bus.m_wline);
        end
    endtask

    task automatic test_iread();
        logic [LINE_W-1:0] a5;
        a5 = {(LINE_W/8){8'hA5}};
        bus.i_req  = 1'b1;
        bus.i_addr = 28'h0000010;
        tick();
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (bus.m_read !== 1'b1 || bus.m_write !== 1'b0 || bus.grant !== 2'b01 || bus.m_addr !== 28'h0000010) begin
                errors++;
                $display("FAIL iread_serve_c%0d: m_read=%b m_write=%b grant=%b m_addr=%h expected 1 0 01 0000010",
                         c, bus.m_read, bus.m_write, bus.grant, bus.m_addr);
            end
            if (c == 4) begin
                bus.m_ready = 1'b1;
                bus.m_line  = a5;
            end
            tick();
        end
        bus.m_ready = 1'b0;
        checks++;
        if (bus.i_ready !== 1'b1 || bus.d_ready !== 1'b0 || bus.i_line !== a5 || bus.m_read !== 1'b0) begin
            errors++;
            $display("FAIL iread_release: i_ready=%b d_ready=%b m_read=%b i_line=%h expected 1 0 0 a5..a5",
                     bus.i_ready, bus.d_ready, bus.m_read, bus.i_line);
        end
        bus.i_req = 1'b0;
        tick();
        checks++;
        if (bus.i_ready !== 1'b0 || bus.grant !== 2'b00) begin
            errors++;
            $display("FAIL iread_pulse_end: i_ready=%b grant=%b expected 0 00", bus.i_ready, bus.grant);
        end
    endtask

    task automatic test_dwrite();
        bus.d_write = 1'b1;
        bus.d_addr  = 28'h0000020;
        bus.d_wline = 128'h1234;
        tick();
        checks++;
        if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0 || bus.m_addr !== 28'h0000020 ||
            bus.m_wline !== 128'h1234 || bus.grant !== 2'b10) begin
            errors++;
            $display("FAIL dwrite_serve: m_write=%b m_read=%b m_addr=%h m_wline=%h grant=%b expected 1 0 0000020 1234 10",
                     bus.m_write, bus.m_read, bus.m_addr, bus.m_wline, bus.grant);
        end
        bus.m_ready = 1'b1;
        bus.m_line  = {LINE_W{1'b1}};
        tick();
        bus.m_ready = 1'b0;
        checks++;
        if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0 || bus.d_line !== '0 || bus.m_write !== 1'b0) begin
            errors++;
            $display("FAIL dwrite_release: d_ready=%b i_ready=%b m_write=%b d_line=%h expected 1 0 0 0",
                     bus.d_ready, bus.i_ready, bus.m_write, bus.d_line);
        end
        bus.d_write = 1'b0;
        tick();
        checks++;
        if (bus.d_ready !== 1'b0) begin
            errors++;
            $display("FAIL dwrite_pulse_end: d_ready=%b expected 0", bus.d_ready);
        end
    endtask

    task automatic test_addr_stable();
        bus.d_read = 1'b1;
        bus.d_addr = 28'h20;
        tick();
        bus.d_addr = 28'h30;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.m_addr !== 28'h20 || bus.m_read !== 1'b1) begin
                errors++;
                $display("FAIL addr_stable_c%0d: m_addr=%h m_read=%b expected 0000020 1", c, bus.m_addr, bus.m_read);
            end
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        bus.d_read  = 1'b0;
        checks++;
        if (bus.d_ready !== 1'b1) begin
            errors++;
            $display("FAIL addr_stable_ready: d_ready=%b expected 1", bus.d_ready);
        end
        tick();
    endtask

    task automatic test_tie();
        logic [1:0] exp;
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 28'h100;
        bus.d_read = 1'b1;
        bus.d_addr = 28'h200;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp = (RR && (k % 2 == 1)) ? 2'b01 : 2'b10;
            checks++;
            if (bus.grant !== exp) begin
                errors++;
                $display("FAIL tie_grant_%0d: got %b expected %b", k, bus.grant, exp);
            end
            bus.m_ready = 1'b1;
            tick();
            bus.m_ready = 1'b0;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 28'h44;
        tick();
        tick();
        rst       = 1'b1;
        bus.i_req = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.m_read, bus.m_write, bus.i_ready, bus.d_ready, bus.grant} !== 6'b0 || bus.m_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: ctrl=%b m_addr=%h expected 0",
                     {bus.m_read, bus.m_write, bus.i_ready, bus.d_ready, bus.grant}, bus.m_addr);
        end
        bus.m_ready = 1'b1;
        bus.m_line  = rand_line();
        tick();
        bus.m_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bus.i_ready !== 1'b0 || bus.m_read !== 1'b0 || bus.grant !== 2'b00 || bus.i_line !== '0) begin
                errors++;
                $display("FAIL reset_mid_late_ready_%0d: i_ready=%b m_read=%b grant=%b i_line=%h expected 0",
                         c, bus.i_ready, bus.m_read, bus.grant, bus.i_line);
            end
            tick();
        end
    endtask

    task automatic test_idle_mready();
        do_reset();
        bus.m_ready = 1'b1;
        bus.m_line  = rand_line();
        tick();
        bus.m_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({bus.i_ready, bus.d_ready, bus.m_read, bus.m_write, bus.grant} !== 6'b0 ||
                bus.i_line !== '0 || bus.d_line !== '0) begin
                errors++;
                $display("FAIL idle_mready_%0d: ctrl=%b i_line=%h d_line=%h expected 0",
                         c, {bus.i_ready, bus.d_ready, bus.m_read, bus.m_write, bus.grant}, bus.i_line, bus.d_line);
            end
            tick();
        end
    endtask

    // Transaction-level model: each requester is either pending or not; the
    // winner follows the tie rule, and each requester's last returned line is
    // what its line output must show.
    task automatic test_random(input int n);
        bit                pi, pd, dr, dw, win_d, last_d, exp_write;
        logic [ADDR_W-1:0] ia, da, exp_addr;
        logic [LINE_W-1:0] dwl, ml, exp_il, exp_dl;
        int                lat;
        do_reset();
        pi = 0; pd = 0; last_d = 0; dr = 0; dw = 0;
        ia = '0; da = '0; dwl = '0;
        exp_il = '0; exp_dl = '0;
        for (int t = 0; t < n; t++) begin
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1;
                ia = ADDR_W'($urandom());
            end
            if (!pd && ($urandom_range(0, 1) == 1 || !pi)) begin
                pd  = 1;
                da  = ADDR_W'($urandom());
                dwl = rand_line();
                case ($urandom_range(0, 2))
                    0:       begin dr = 1; dw = 0; end
                    1:       begin dr = 0; dw = 1; end
                    default: begin dr = 1; dw = 1; end
                endcase
            end
            bus.i_req   = pi;
            bus.i_addr  = ia;
            bus.d_read  = pd & dr;
            bus.d_write = pd & dw;
            bus.d_addr  = da;
            bus.d_wline = dwl;

            win_d     = pd && (!pi || !(RR && last_d));
            exp_addr  = win_d ? da : ia;
            exp_write = win_d && dw;
            tick();
            checks++;
            if (bus.grant !== (win_d ? 2'b10 : 2'b01) || bus.m_read !== !exp_write ||
                bus.m_write !== exp_write || bus.m_addr !== exp_addr ||
                (exp_write && bus.m_wline !== dwl)) begin
                errors++;
                $display("FAIL rand_start_%0d: grant=%b rd=%b wr=%b addr=%h expected grant=%b rd=%b wr=%b addr=%h",
                         t, bus.grant, bus.m_read, bus.m_write, bus.m_addr,
                         win_d ? 2'b10 : 2'b01, !exp_write, exp_write, exp_addr);
            end

            lat = $urandom_range(0, 4);
            for (int c = 0; c < lat; c++) begin
                if (win_d) bus.d_addr = ADDR_W'($urandom());
                else       bus.i_addr = ADDR_W'($urandom());
                tick();
                checks++;
                if (bus.m_read !== !exp_write || bus.m_write !== exp_write ||
                    bus.m_addr !== exp_addr || bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_hold_%0d_%0d: rd=%b wr=%b addr=%h rdy=%b%b expected rd=%b wr=%b addr=%h rdy=00",
                             t, c, bus.m_read, bus.m_write, bus.m_addr, bus.i_ready, bus.d_ready,
                             !exp_write, exp_write, exp_addr);
                end
            end

            ml          = rand_line();
            bus.m_ready = 1'b1;
            bus.m_line  = ml;
            tick();
            bus.m_ready = 1'b0;
            if (!win_d)                 exp_il = ml;
            else if (!exp_write)        exp_dl = ml;
            checks++;
            if ({bus.m_read, bus.m_write, bus.grant} !== 4'b0 || bus.i_ready !== !win_d ||
                bus.d_ready !== win_d || bus.i_line !== exp_il || bus.d_line !== exp_dl) begin
                errors++;
                $display("FAIL rand_release_%0d: ctrl=%b rdy=%b%b i_line=%h d_line=%h expected rdy=%b%b i_line=%h d_line=%h",
                         t, {bus.m_read, bus.m_write, bus.grant}, bus.i_ready, bus.d_ready,
                         bus.i_line, bus.d_line, !win_d, win_d, exp_il, exp_dl);
            end

            if (win_d) begin
                pd = 0;
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end else begin
                pi = 0;
                bus.i_req = 1'b0;
            end
            last_d = win_d;
            tick();
            checks++;
            if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0 || bus.grant !== 2'b00) begin
                errors++;
                $display("FAIL rand_idle_%0d: rdy=%b%b grant=%b expected 00 00",
                         t, bus.i_ready, bus.d_ready, bus.grant);
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_iread();
        test_dwrite();
        test_addr_stable();
        test_tie();
        test_reset_mid();
        test_idle_mready();
        test_random(60);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
